// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, immediate formats, execute payload.
// Opcode classification lives here so decode and imm_gen agree on one table.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_R
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        illegal;
    } ex_payload_t;

    typedef struct packed {
        logic     legal;
        logic     writes_rd;
        logic     uses_rs1;
        logic     uses_rs2;
        imm_fmt_e fmt;
    } op_class_t;

    // Unknown opcodes come back as R-format with no register usage, so they never stall.
    function automatic op_class_t classify(input logic [6:0] opc);
        op_class_t c;
        c = '{legal: 1'b0, writes_rd: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0, fmt: IMM_R};
        case (opc)
            OPC_LUI, OPC_AUIPC: c = '{1'b1, 1'b1, 1'b0, 1'b0, IMM_U};
            OPC_JAL:            c = '{1'b1, 1'b1, 1'b0, 1'b0, IMM_J};
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:
                                c = '{1'b1, 1'b1, 1'b1, 1'b0, IMM_I};
            OPC_OP:             c = '{1'b1, 1'b1, 1'b1, 1'b1, IMM_R};
            OPC_BRANCH:         c = '{1'b1, 1'b0, 1'b1, 1'b1, IMM_B};
            OPC_STORE:          c = '{1'b1, 1'b0, 1'b1, 1'b1, IMM_S};
            OPC_MISC_MEM, OPC_SYSTEM:
                                c = '{1'b1, 1'b0, 1'b1, 1'b0, IMM_I};
            default:            c = '{1'b0, 1'b0, 1'b0, 1'b0, IMM_R};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch / register-file / writeback / execute signals seen by the decode stage.
// slave = decode_stage side, master = surrounding pipeline.
interface decode_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic [31:0]     rf_rs1_data;
    logic [31:0]     rf_rs2_data;

    logic            wb_w_en;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_rdv;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [31:0]     ex_rs1_val;
    logic [31:0]     ex_rs2_val;
    logic [31:0]     ex_imm;
    logic [4:0]      ex_rd;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc,
        output id_ready,
        output rf_rs1, rf_rs2,
        input  rf_rs1_data, rf_rs2_data,
        input  wb_w_en, wb_rd, wb_rdv,
        output ex_valid,
        input  ex_ready,
        output ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
        output ex_opcode, ex_funct3, ex_funct7b5, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc,
        input  id_ready,
        input  rf_rs1, rf_rs2,
        output rf_rs1_data, rf_rs2_data,
        output wb_w_en, wb_rd, wb_rdv,
        input  ex_valid,
        output ex_ready,
        input  ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
        input  ex_opcode, ex_funct3, ex_funct7b5, ex_illegal
    );

endinterface

// File: rtl/imm_gen.sv
// Sign-extended immediate for the I/S/B/U/J formats; R-format yields zero.
// Purely combinational, no state, no backpressure.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
            IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage with register scoreboard; optional writeback bypass under DECODE_BYPASS_EN.
// Latency 1: accepted instruction appears on ex_* the following cycle.
// Backpressure: id_ready drops on RAW/WAW hazard or while ex holds an un-taken payload.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    decode_if.slave bus
);

    logic [31:0]     instr;
    logic [XLEN-1:0] pc_in;
    logic [4:0]      rs1, rs2, rd;
    op_class_t       cls;
    logic [31:0]     imm_val;

    logic [31:0]     busy, busy_nxt, set_mask, clr_mask;
    logic            run_q;
    logic            ex_valid_q;
    ex_payload_t     ex_q, payload;

    logic            rs1_stall, rs2_stall, waw_stall, hazard;
    logic            id_ready, accept;
    logic [31:0]     rs1_val, rs2_val;

    assign instr = bus.if_instr;
    assign pc_in = bus.if_pc;
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign rd    = instr[11:7];
    assign cls   = classify(instr[6:0]);

    assign bus.rf_rs1 = rs1;
    assign bus.rf_rs2 = rs2;

    imm_gen u_imm_gen (
        .instr (instr[31:7]),
        .fmt   (cls.fmt),
        .imm   (imm_val)
    );

`ifdef DECODE_BYPASS_EN
    logic wb_hit1, wb_hit2;
    assign wb_hit1   = bus.wb_w_en && (bus.wb_rd == rs1) && (rs1 != 5'd0);
    assign wb_hit2   = bus.wb_w_en && (bus.wb_rd == rs2) && (rs2 != 5'd0);
    assign rs1_stall = cls.uses_rs1 && busy[rs1] && !wb_hit1;
    assign rs2_stall = cls.uses_rs2 && busy[rs2] && !wb_hit2;
    assign rs1_val   = (rs1 == 5'd0) ? 32'd0 : (wb_hit1 ? bus.wb_rdv : bus.rf_rs1_data);
    assign rs2_val   = (rs2 == 5'd0) ? 32'd0 : (wb_hit2 ? bus.wb_rdv : bus.rf_rs2_data);
`else
    // A source being written this cycle waits until the register file has the value.
    assign rs1_stall = cls.uses_rs1 && busy[rs1];
    assign rs2_stall = cls.uses_rs2 && busy[rs2];
    assign rs1_val   = (rs1 == 5'd0) ? 32'd0 : bus.rf_rs1_data;
    assign rs2_val   = (rs2 == 5'd0) ? 32'd0 : bus.rf_rs2_data;
`endif

    assign waw_stall = cls.writes_rd && (rd != 5'd0) && busy[rd];
    assign hazard    = bus.if_valid && (rs1_stall || rs2_stall || waw_stall);
    assign id_ready  = run_q && !hazard && (!ex_valid_q || bus.ex_ready);
    assign accept    = bus.if_valid && id_ready;
    assign bus.id_ready = id_ready;

    // Set is applied after clear so a same-cycle set/clear of one register leaves it busy.
    assign set_mask = (accept && cls.writes_rd && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;
    assign clr_mask = bus.wb_w_en ? (32'd1 << bus.wb_rd) : 32'd0;
    assign busy_nxt = ((busy & ~clr_mask) | set_mask) & ~32'd1;

    always_comb begin
        payload          = '0;
        payload.pc       = pc_in;
        payload.rs1_val  = rs1_val;
        payload.rs2_val  = rs2_val;
        payload.imm      = imm_val;
        payload.rd       = cls.writes_rd ? rd : 5'd0;
        payload.opcode   = instr[6:0];
        payload.funct3   = instr[14:12];
        payload.funct7b5 = instr[30];
        payload.illegal  = !cls.legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            busy       <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            run_q <= 1'b1;
            busy  <= busy_nxt;
            if (accept) begin
                ex_q       <= payload;
                ex_valid_q <= 1'b1;
            end else if (bus.ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_rs1_val  = ex_q.rs1_val;
    assign bus.ex_rs2_val  = ex_q.rs2_val;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_opcode   = ex_q.opcode;
    assign bus.ex_funct3   = ex_q.funct3;
    assign bus.ex_funct7b5 = ex_q.funct7b5;
    assign bus.ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scenarios followed by a randomized run checked against a behavioural model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment register file: x0 deliberately holds garbage.
    logic [31:0] regs [32] = '{default: 32'hDEAD_BEEF};
    assign bus.rf_rs1_data = regs[bus.rf_rs1];
    assign bus.rf_rs2_data = regs[bus.rf_rs2];
    always @(posedge clk) if (bus.wb_w_en) regs[bus.wb_rd] <= bus.wb_rdv;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_writer(input logic [6:0] op);
        return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
    endfunction
    function automatic bit is_legal(input logic [6:0] op);
        return is_writer(op) || (op inside {7'h63, 7'h23, 7'h0F, 7'h73});
    endfunction
    function automatic bit reads_rs1(input logic [6:0] op);
        return is_legal(op) && !(op inside {7'h37, 7'h17, 7'h6F});
    endfunction
    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [31:0] s;
        s = {32{ins[31]}};
        case (ins[6:0])
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: return (s << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            7'h63: return (s << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'h23: return (s << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return (s << 11) | 32'(ins[30:20]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(11))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h03;  5: op = 7'h13;  6: op = 7'h33;  7: op = 7'h63;
            8: op = 7'h23;  9: op = 7'h0F; 10: op = 7'h73;
            default: op = ($urandom_range(1) == 0) ? 7'h7F : 7'h0B;
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(7));
        w[19:15] = 5'($urandom_range(7));
        w[24:20] = 5'($urandom_range(7));
        return w;
    endfunction

    // Behavioural model state
    logic [31:0] m_busy;
    bit          m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_misc;
    logic [31:0] n_pc, n_rs1, n_rs2, n_imm, n_misc;
    logic [31:0] ins;
    logic [4:0]  r1, r2, rdx, wr;
    bit          blk, exp_rdy, acc, byp, wb_en_s, exr_s;
    logic [4:0]  wb_rd_s;

    function automatic bit src_blocked(input logic [4:0] r, input logic [31:0] bsy,
                                       input bit bypass, input bit wen, input logic [4:0] wrd);
        return (r != 5'd0) && bsy[r] && !(bypass && wen && (wrd == r));
    endfunction

    initial begin
`ifdef DECODE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        rst_n = 1'b0;
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
        bus.wb_w_en = 1'b0; bus.wb_rd = '0; bus.wb_rdv = '0; bus.ex_ready = 1'b1;
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'd0);
        chk("rst_busy", dut.busy, 32'd0);
        chk("rst_payload", bus.ex_pc | bus.ex_imm | bus.ex_rs1_val | bus.ex_rs2_val |
            32'({bus.ex_rd, bus.ex_opcode, bus.ex_funct3, bus.ex_funct7b5, bus.ex_illegal}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_id_ready", 32'(bus.id_ready), 32'd0);

        // addi x5,x0,0x123
        @(negedge clk);
        bus.if_valid = 1'b1; bus.if_instr = 32'h1230_0293; bus.if_pc = 32'h100;
        #1 chk("addi_ready", 32'(bus.id_ready), 32'd1);
        chk("addi_rf_addr", {22'd0, bus.rf_rs1, bus.rf_rs2}, {22'd0, 5'd0, 5'd3});
        @(posedge clk); #1;
        chk("addi_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("addi_ex_rd", 32'(bus.ex_rd), 32'd5);
        chk("addi_ex_imm", bus.ex_imm, 32'h0000_0123);
        chk("addi_ex_rs1_x0", bus.ex_rs1_val, 32'd0);
        chk("addi_ex_pc", bus.ex_pc, 32'h100);
        chk("addi_busy", dut.busy, 32'h0000_0020);

        // add x6,x5,x5 : RAW on x5
        @(negedge clk);
        bus.if_instr = 32'h0052_8333; bus.if_pc = 32'h104;
        #1 chk("raw_stall", 32'(bus.id_ready), 32'd0);
        @(posedge clk); #1 chk("raw_drain", 32'(bus.ex_valid), 32'd0);
        @(negedge clk);
        chk("raw_stall2", 32'(bus.id_ready), 32'd0);
        bus.wb_w_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_rdv = 32'h123;
        #1;
`ifdef DECODE_BYPASS_EN
        chk("byp_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk); #1;
`else
        chk("nobyp_wait", 32'(bus.id_ready), 32'd0);
        @(negedge clk);
        bus.wb_w_en = 1'b0;
        #1 chk("nobyp_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk); #1;
`endif
        chk("raw_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("raw_ex_rd", 32'(bus.ex_rd), 32'd6);
        chk("raw_rs1", bus.ex_rs1_val, 32'h123);
        chk("raw_rs2", bus.ex_rs2_val, 32'h123);
        chk("raw_busy", dut.busy, 32'h0000_0040);
        @(negedge clk);
        bus.if_valid = 1'b0; bus.wb_w_en = 1'b1; bus.wb_rd = 5'd6; bus.wb_rdv = 32'h246;
        @(negedge clk);
        bus.wb_w_en = 1'b0;

        // x0 destination / x0 sources
        bus.if_valid = 1'b1; bus.if_instr = 32'h0000_0013;
        #1 chk("nop_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk); #1;
        chk("nop_rd", 32'(bus.ex_rd), 32'd0);
        chk("nop_busy", dut.busy, 32'd0);
        @(negedge clk);
        bus.if_instr = 32'h0000_0033;
        #1 chk("x0_nostall", 32'(bus.id_ready), 32'd1);
        @(posedge clk); #1;
        chk("x0_rs1", bus.ex_rs1_val, 32'd0);
        chk("x0_rs2", bus.ex_rs2_val, 32'd0);
        chk("x0_busy", dut.busy, 32'd0);

        // Backpressure: hold ex_ready low for 3 cycles
        @(negedge clk); bus.if_valid = 1'b0;
        @(negedge clk);
        bus.ex_ready = 1'b0; bus.if_valid = 1'b1; bus.if_instr = 32'h0070_0093;
        #1 chk("bp_first_ready", 32'(bus.id_ready), 32'd1);
        @(negedge clk);
        bus.if_instr = 32'h0090_0113;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_id_ready", 32'(bus.id_ready), 32'd0);
            chk("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
            chk("bp_ex_imm", bus.ex_imm, 32'd7);
            chk("bp_ex_rd", 32'(bus.ex_rd), 32'd1);
            @(negedge clk);
        end
        bus.ex_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("b2b_ex_rd", 32'(bus.ex_rd), 32'd2);
        chk("b2b_ex_imm", bus.ex_imm, 32'd9);
        @(negedge clk); bus.if_valid = 1'b0;
        @(posedge clk); #1 chk("b2b_drain", 32'(bus.ex_valid), 32'd0);
        @(negedge clk); bus.wb_w_en = 1'b1; bus.wb_rd = 5'd1;
        @(negedge clk); bus.wb_rd = 5'd2;
        @(negedge clk); bus.wb_w_en = 1'b0;

        // Branch immediate and illegal opcode
        bus.if_valid = 1'b1; bus.if_instr = 32'hFE00_0EE3;
        #1 chk("beq_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk); #1;
        chk("beq_imm", bus.ex_imm, 32'hFFFF_FFFC);
        chk("beq_rd", 32'(bus.ex_rd), 32'd0);
        chk("beq_illegal", 32'(bus.ex_illegal), 32'd0);
        @(negedge clk);
        bus.if_instr = 32'hFFFF_FFFF;
        #1 chk("ill_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk); #1;
        chk("ill_flag", 32'(bus.ex_illegal), 32'd1);
        chk("ill_rd", 32'(bus.ex_rd), 32'd0);
        chk("ill_busy", dut.busy, 32'd0);
        @(negedge clk); bus.if_valid = 1'b0;

        // Randomized phase from a fresh reset
        rst_n = 1'b0;
        #1 chk("rand_rst_busy", dut.busy, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
        m_busy = '0; m_valid = 1'b0;
        m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_misc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.if_valid = ($urandom_range(3) != 0);
            bus.if_instr = gen_instr();
            bus.if_pc    = $urandom;
            bus.ex_ready = ($urandom_range(3) != 0);
            bus.wb_w_en  = ($urandom_range(1) == 1);
            wr = 5'($urandom_range(7));
            for (int k = 1; k < 8; k++)
                if (m_busy[k] && ($urandom_range(1) == 1)) wr = 5'(k);
            bus.wb_rd  = wr;
            bus.wb_rdv = $urandom;
            #1;
            ins = bus.if_instr;
            r1  = ins[19:15];
            r2  = ins[24:20];
            rdx = ins[11:7];
            blk = (reads_rs1(ins[6:0]) && src_blocked(r1, m_busy, byp, bus.wb_w_en, bus.wb_rd)) ||
                  (reads_rs2(ins[6:0]) && src_blocked(r2, m_busy, byp, bus.wb_w_en, bus.wb_rd)) ||
                  (is_writer(ins[6:0]) && (rdx != 5'd0) && m_busy[rdx]);
            exp_rdy = !(bus.if_valid && blk) && (!m_valid || bus.ex_ready);
            chk("rand_id_ready", 32'(bus.id_ready), 32'(exp_rdy));
            chk("rand_rf_addr", {22'd0, bus.rf_rs1, bus.rf_rs2}, {22'd0, r1, r2});
            acc = bus.if_valid && exp_rdy;
            n_pc  = bus.if_pc;
            n_rs1 = (r1 == 5'd0) ? 32'd0 :
                    (byp && bus.wb_w_en && bus.wb_rd == r1) ? bus.wb_rdv : regs[r1];
            n_rs2 = (r2 == 5'd0) ? 32'd0 :
                    (byp && bus.wb_w_en && bus.wb_rd == r2) ? bus.wb_rdv : regs[r2];
            n_imm = ref_imm(ins);
            n_misc = 32'({(is_writer(ins[6:0]) ? rdx : 5'd0), ins[6:0], ins[14:12], ins[30],
                          !is_legal(ins[6:0])});
            wb_en_s = bus.wb_w_en; wb_rd_s = bus.wb_rd; exr_s = bus.ex_ready;
            @(posedge clk);
            if (wb_en_s) m_busy[wb_rd_s] = 1'b0;
            if (acc && is_writer(ins[6:0]) && rdx != 5'd0) m_busy[rdx] = 1'b1;
            m_busy[0] = 1'b0;
            if (acc) begin
                m_valid = 1'b1;
                m_pc = n_pc; m_rs1 = n_rs1; m_rs2 = n_rs2; m_imm = n_imm; m_misc = n_misc;
            end else if (exr_s) begin
                m_valid = 1'b0;
            end
            #1;
            chk("rand_ex_valid", 32'(bus.ex_valid), 32'(m_valid));
            chk("rand_busy", dut.busy, m_busy);
            if (m_valid) begin
                chk("rand_ex_pc", bus.ex_pc, m_pc);
                chk("rand_ex_rs1", bus.ex_rs1_val, m_rs1);
                chk("rand_ex_rs2", bus.ex_rs2_val, m_rs2);
                chk("rand_ex_imm", bus.ex_imm, m_imm);
                chk("rand_ex_fields", 32'({bus.ex_rd, bus.ex_opcode, bus.ex_funct3,
                                            bus.ex_funct7b5, bus.ex_illegal}), m_misc);
            end
        end

        // Asynchronous reset mid-cycle with a live payload and busy x5
        @(negedge clk);
        rst_n = 1'b0; bus.if_valid = 1'b0; bus.wb_w_en = 1'b0; bus.ex_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        bus.if_valid = 1'b1; bus.if_instr = 32'h1230_0293; bus.if_pc = 32'h200;
        @(posedge clk); #1;
        chk("arst_pre_valid", 32'(bus.ex_valid), 32'd1);
        chk("arst_pre_busy", dut.busy, 32'h0000_0020);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("arst_busy", dut.busy, 32'd0);
        chk("arst_payload", bus.ex_imm | bus.ex_pc | 32'(bus.ex_rd), 32'd0);
        chk("arst_id_ready", 32'(bus.id_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, operand/PC/immediate width; only 32 is supported.
REQ-002 One clock; reset is asynchronous and active-low. Ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 if_valid  in  1 / if_instr  in  32 / if_pc  in  XLEN: instruction offered by fetch.
REQ-005 id_ready  out  1  decode accepts if_instr this cycle.
REQ-006 rf_rs1, rf_rs2  out  5  register-file read addresses; rf_rs1_data, rf_rs2_data  in  32  combinational read data.
REQ-007 wb_w_en  in  1 / wb_rd  in  5 / wb_rdv  in  32: writeback port, the same signals driving the register-file write port.
REQ-008 ex_valid  out  1 / ex_ready  in  1: handshake to execute.
REQ-009 Execute payload, all out: ex_pc XLEN, ex_rs1_val 32, ex_rs2_val 32, ex_imm 32, ex_rd 5, ex_opcode 7, ex_funct3 3, ex_funct7b5 1, ex_illegal 1.

Function
REQ-010 rf_rs1 = if_instr[19:15] and rf_rs2 = if_instr[24:20], combinationally, every cycle.
REQ-011 Accept when if_valid && id_ready at a rising edge; the payload is registered and ex_valid=1 from the next cycle (latency 1).
REQ-012 id_ready = !hazard && (!ex_valid || ex_ready); ex_* held stable while ex_valid && !ex_ready.
REQ-013 ex_valid clears after an ex_ready handshake with no new acceptance; accept and drain in the same cycle give back-to-back issue.
REQ-014 Writers of rd: LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, LOAD 0x03, OP-IMM 0x13, OP 0x33; BRANCH 0x63, STORE 0x23, MISC-MEM 0x0F, SYSTEM 0x73 write none.
REQ-015 rs1 is used by every opcode except LUI/AUIPC/JAL; rs2 is used by BRANCH/STORE/OP only.
REQ-016 Any other opcode sets ex_illegal=1, ex_rd=0, and no scoreboard update.
REQ-017 ex_imm is sign-extended per I/S/B/U/J format: U = instr[31:12]<<12; B/J LSB=0; R-type = 0.
REQ-018 Scoreboard: 32-bit busy vector; bit set on accept of a writer with rd!=0; bit cleared when wb_w_en && wb_rd matches; set wins on same-cycle set/clear of one register.
REQ-019 busy[0] is constant 0; writes to x0 never stall.
REQ-020 hazard = if_valid && (used rs1/rs2 busy, or rd busy (WAW)), subject to REQ-024.
REQ-021 An operand read from x0 is 0 regardless of rf data.

Reset
REQ-022 While rst_n=0: ex_valid=0, busy=0, and all ex_* payload outputs 0; takes effect immediately, mid-stall or mid-handshake.
REQ-023 id_ready is 0 during reset and evaluated per REQ-012 from the first edge after release.

Configuration
REQ-024 With DECODE_BYPASS_EN defined: a busy source with wb_w_en && wb_rd==src && src!=0 in the same cycle is not a hazard, and wb_rdv is captured instead of rf data.
REQ-025 Without DECODE_BYPASS_EN: such a source stalls one extra cycle and is read from the register file after the write commits.

Structure
REQ-026 Package decode_pkg holds opcode localparams, the imm-format enum (IMM_I/S/B/U/J/R), and the ex payload struct.
REQ-027 Immediate generation lives in sub-module imm_gen (combinational); the scoreboard and pipeline register stay in decode_stage.

Verification
REQ-028 Reset, ex_ready=1, present 0x12300293 (addi x5,x0,0x123) -> next cycle ex_valid=1, ex_rd=5, ex_imm=0x00000123, busy[5]=1.
REQ-029 Then present 0x00528333 (add x6,x5,x5) -> id_ready=0 until wb_w_en=1, wb_rd=5, wb_rdv=0x123. With the bypass compiled in, the instruction is accepted that cycle with ex_rs1_val=ex_rs2_val=0x123. Without it, the instruction is accepted one cycle later.
REQ-030 Present 0x00000013 (addi x0) then an instruction reading x0 -> no stall, operands 0, busy stays 0.
REQ-031 ex_ready=0 for 3 cycles with a second instruction offered -> ex_* unchanged, id_ready=0; ex_ready=1 -> both issue back-to-back.
REQ-032 Present 0xFE000EE3 (beq x0,x0,-4) -> ex_imm=0xFFFFFFFC, ex_rd=0. Present 0xFFFFFFFF -> ex_illegal=1, busy unchanged.
REQ-033 Assert rst_n=0 mid-cycle with ex_valid=1 and busy[5]=1 -> ex_valid and busy clear immediately, without waiting for a clock edge.
